// File: rtl/hsv_pkg.sv
// Shared fp32 constants, the H/S/V pixel bundle and the fp32 ordering key
// used by the threshold-mask datapath.
package hsv_pkg;

  localparam int FP32_W = 32;

  localparam logic [FP32_W-1:0] FP32_QNAN = 32'h7FC0_0000;
  localparam logic [FP32_W-1:0] FP32_ZERO = 32'h0000_0000;
  localparam logic [FP32_W-1:0] FP32_ONE  = 32'h3F80_0000;
  localparam logic [FP32_W-1:0] FP32_360  = 32'h43B4_0000;

  typedef struct packed {
    logic [FP32_W-1:0] h;
    logic [FP32_W-1:0] s;
    logic [FP32_W-1:0] v;
  } hsv_px_t;

  // Maps sign-magnitude fp32 onto an unsigned key with the same ordering.
  // Both zeros share one key so that -0 == +0.
  function automatic logic [FP32_W-1:0] fp32_key(input logic [FP32_W-1:0] f);
    if (f[FP32_W-2:0] == '0)
      return {1'b1, {(FP32_W-1){1'b0}}};
    else if (f[FP32_W-1])
      return ~f;
    else
      return {1'b1, f[FP32_W-2:0]};
  endfunction

  function automatic logic fp32_is_nan(input logic [FP32_W-1:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] != '0);
  endfunction

endpackage

// File: rtl/fp32_cmp.sv
// Combinational fp32 comparator: a<b, a==b, and unordered when either is NaN.
// Denormals are compared exactly; infinities order normally.
module fp32_cmp
  import hsv_pkg::*;
(
  input  logic [FP32_W-1:0] a,
  input  logic [FP32_W-1:0] b,
  output logic              lt,
  output logic              eq,
  output logic              unordered
);

  logic [FP32_W-1:0] key_a;
  logic [FP32_W-1:0] key_b;

  assign key_a     = fp32_key(a);
  assign key_b     = fp32_key(b);
  assign unordered = fp32_is_nan(a) | fp32_is_nan(b);
  assign lt        = ~unordered & (key_a < key_b);
  assign eq        = ~unordered & (key_a == key_b);

endmodule

// File: rtl/hsv_threshold_mask.sv
// Per-pixel H/S/V range test with raster position, per-frame match count and
// end-of-frame pulse. Fixed two-clock latency from an accepted input to its output.
module hsv_threshold_mask
  import hsv_pkg::*;
#(
  parameter  int Width  = 437,
  parameter  int Height = 350,
  localparam int XW     = $clog2(Width),
  localparam int YW     = $clog2(Height),
  localparam int CW     = $clog2(Width * Height + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              In_Valid,
  input  logic [FP32_W-1:0] H,
  input  logic [FP32_W-1:0] S,
  input  logic [FP32_W-1:0] V,
  input  logic [FP32_W-1:0] H_Lo,
  input  logic [FP32_W-1:0] H_Hi,
  input  logic [FP32_W-1:0] S_Lo,
  input  logic [FP32_W-1:0] S_Hi,
  input  logic [FP32_W-1:0] V_Lo,
  input  logic [FP32_W-1:0] V_Hi,
  output logic              Out_Valid,
  output logic              Mask,
  output logic [XW-1:0]     X,
  output logic [YW-1:0]     Y,
  output logic              Frame_Done,
  output logic [CW-1:0]     Match_Count
);

  localparam logic [XW-1:0] X_LAST  = XW'(Width - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(Height - 1);
  localparam logic [CW-1:0] ACC_MAX = CW'(Width * Height);

  logic [XW-1:0]     in_x_reg;
  logic [YW-1:0]     in_y_reg;
  logic              s0_valid_reg;
  hsv_px_t           s0_px_reg;
  logic [XW-1:0]     s0_x_reg;
  logic [YW-1:0]     s0_y_reg;
  logic [FP32_W-1:0] bound_reg [6];
  logic              s1_valid_reg;
  logic [5:0]        s1_hit_reg;
  logic              s1_hue_ord_reg;
  logic [XW-1:0]     s1_x_reg;
  logic [YW-1:0]     s1_y_reg;
  logic [CW-1:0]     acc_reg;

  logic [FP32_W-1:0] cmp_a [6];
  logic [5:0]        cmp_lt;
  logic [5:0]        cmp_eq;
  logic [5:0]        cmp_un;
  logic [5:0]        hit;
  logic              frame_start;
  logic              hue_hit;
  logic              mask_c;
  logic              last_c;

  assign frame_start = In_Valid && (in_x_reg == '0) && (in_y_reg == '0);

  // Even slots test value >= low bound, odd slots test value <= high bound.
  always_comb begin
    cmp_a[0] = s0_px_reg.h;
    cmp_a[1] = s0_px_reg.h;
    cmp_a[2] = s0_px_reg.s;
    cmp_a[3] = s0_px_reg.s;
    cmp_a[4] = s0_px_reg.v;
    cmp_a[5] = s0_px_reg.v;
  end

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_cmp
      fp32_cmp u_cmp (
        .a         (cmp_a[gi]),
        .b         (bound_reg[gi]),
        .lt        (cmp_lt[gi]),
        .eq        (cmp_eq[gi]),
        .unordered (cmp_un[gi])
      );
      if (gi % 2 == 0) begin : g_ge
        assign hit[gi] = ~cmp_lt[gi] & ~cmp_un[gi];
      end else begin : g_le
        assign hit[gi] = cmp_lt[gi] | cmp_eq[gi];
      end
    end
  endgenerate

  // A low hue bound above the high bound selects the range wrapping through 0.
  assign hue_hit = s1_hue_ord_reg ? (s1_hit_reg[0] & s1_hit_reg[1])
                                  : (s1_hit_reg[0] | s1_hit_reg[1]);
  assign mask_c  = hue_hit & (&s1_hit_reg[5:2]);
  assign last_c  = (s1_x_reg == X_LAST) && (s1_y_reg == Y_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_x_reg     <= '0;
      in_y_reg     <= '0;
      s0_valid_reg <= 1'b0;
      s0_px_reg    <= '0;
      s0_x_reg     <= '0;
      s0_y_reg     <= '0;
      for (int i = 0; i < 6; i++) bound_reg[i] <= '0;
    end else begin
      s0_valid_reg <= In_Valid;
      if (In_Valid) begin
        s0_px_reg <= '{h: H, s: S, v: V};
        s0_x_reg  <= in_x_reg;
        s0_y_reg  <= in_y_reg;
        if (in_x_reg == X_LAST) begin
          in_x_reg <= '0;
          in_y_reg <= (in_y_reg == Y_LAST) ? '0 : in_y_reg + 1'b1;
        end else begin
          in_x_reg <= in_x_reg + 1'b1;
        end
      end
      if (frame_start) begin
        bound_reg[0] <= H_Lo;
        bound_reg[1] <= H_Hi;
        bound_reg[2] <= S_Lo;
        bound_reg[3] <= S_Hi;
        bound_reg[4] <= V_Lo;
        bound_reg[5] <= V_Hi;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg   <= 1'b0;
      s1_hit_reg     <= '0;
      s1_hue_ord_reg <= 1'b0;
      s1_x_reg       <= '0;
      s1_y_reg       <= '0;
    end else begin
      s1_valid_reg   <= s0_valid_reg;
      s1_hit_reg     <= hit;
      s1_hue_ord_reg <= fp32_key(bound_reg[0]) <= fp32_key(bound_reg[1]);
      s1_x_reg       <= s0_x_reg;
      s1_y_reg       <= s0_y_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Out_Valid   <= 1'b0;
      Mask        <= 1'b0;
      X           <= '0;
      Y           <= '0;
      Frame_Done  <= 1'b0;
      Match_Count <= '0;
      acc_reg     <= '0;
    end else begin
      Out_Valid  <= s1_valid_reg;
      Frame_Done <= s1_valid_reg & last_c;
      if (s1_valid_reg) begin
        Mask <= mask_c;
        X    <= s1_x_reg;
        Y    <= s1_y_reg;
        if (last_c) begin
          Match_Count <= (acc_reg == ACC_MAX) ? acc_reg : acc_reg + CW'(mask_c);
          acc_reg     <= '0;
        end else if (mask_c && acc_reg != ACC_MAX) begin
          acc_reg <= acc_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hsv_threshold_mask.sv
// Scoreboard bench for hsv_threshold_mask on a 4x2 frame: expected outputs are
// queued as pixels are driven and matched against the captured output stream.
module tb_hsv_threshold_mask;

  localparam int W  = 4;
  localparam int HT = 2;
  localparam int K  = 30;

  localparam logic [31:0] F0    = 32'h0000_0000;
  localparam logic [31:0] FNEG0 = 32'h8000_0000;
  localparam logic [31:0] F10   = 32'h4120_0000;
  localparam logic [31:0] F20   = 32'h41A0_0000;
  localparam logic [31:0] F30   = 32'h41F0_0000;
  localparam logic [31:0] F60   = 32'h4270_0000;
  localparam logic [31:0] F180  = 32'h4334_0000;
  localparam logic [31:0] F340  = 32'h43AA_0000;
  localparam logic [31:0] F350  = 32'h43AF_0000;
  localparam logic [31:0] F05   = 32'h3F00_0000;
  localparam logic [31:0] FN05  = 32'hBF00_0000;
  localparam logic [31:0] F08   = 32'h3F4C_CCCD;
  localparam logic [31:0] F09   = 32'h3F66_6666;
  localparam logic [31:0] F1    = 32'h3F80_0000;
  localparam logic [31:0] FNAN  = 32'h7FC0_0000;

  logic        clk = 1'b0;
  logic        rst_n, in_valid;
  logic [31:0] h, s, v, h_lo, h_hi, s_lo, s_hi, v_lo, v_hi;
  logic        out_valid, mask, frame_done;
  logic [1:0]  x;
  logic [0:0]  y;
  logic [3:0]  match_count;

  always #K clk = ~clk;

  hsv_threshold_mask #(.Width(W), .Height(HT)) dut (
    .clk(clk), .rst_n(rst_n), .In_Valid(in_valid),
    .H(h), .S(s), .V(v),
    .H_Lo(h_lo), .H_Hi(h_hi), .S_Lo(s_lo), .S_Hi(s_hi), .V_Lo(v_lo), .V_Hi(v_hi),
    .Out_Valid(out_valid), .Mask(mask), .X(x), .Y(y),
    .Frame_Done(frame_done), .Match_Count(match_count)
  );

  typedef struct packed {
    logic       m;
    logic [1:0] x;
    logic [0:0] y;
    logic       fd;
    logic [3:0] mc;
  } out_t;

  out_t exp_q[$];
  out_t act_q[$];
  int   tests = 0, fails = 0, stray_fd = 0;
  int   bx = 0, by = 0, bacc = 0, bmc = 0;

  always @(negedge clk) begin
    if (out_valid) act_q.push_back(out_t'({mask, x, y, frame_done, match_count}));
    else if (frame_done) stray_fd++;
  end

  task automatic set_bounds(input logic [31:0] hl, hh, sl, sh, vl, vh);
    h_lo = hl; h_hi = hh; s_lo = sl; s_hi = sh; v_lo = vl; v_hi = vh;
  endtask

  task automatic send_px(input logic [31:0] hh, ss, vv, input bit m);
    out_t e;
    @(negedge clk);
    in_valid = 1'b1; h = hh; s = ss; v = vv;
    if (m) bacc++;
    e.m  = m;
    e.x  = bx[1:0];
    e.y  = by[0:0];
    e.fd = (bx == W - 1) && (by == HT - 1);
    if (e.fd) begin bmc = bacc; bacc = 0; end
    e.mc = bmc[3:0];
    exp_q.push_back(e);
    bx++;
    if (bx == W) begin bx = 0; by++; if (by == HT) by = 0; end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); in_valid = 1'b0; end
  endtask

  task automatic pad(input logic [31:0] hh, ss, vv, input bit m);
    while (bx != 0 || by != 0) send_px(hh, ss, vv, m);
  endtask

  // Waits (bounded) for every queued expectation to have an output, then settles.
  task automatic drain(output bit ok);
    ok = 1'b0;
    idle(1);
    for (int i = 0; i < 40; i++) begin
      if (act_q.size() >= exp_q.size()) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    idle(3);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0;
    h = F0; s = F0; v = F0;
    set_bounds(F0, F0, F0, F0, F0, F0);
    repeat (2) @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || frame_done !== 1'b0) begin
      fails++; $display("FAIL reset_valid got ov=%b fd=%b want 0 0", out_valid, frame_done);
    end
    tests++;
    if (mask !== 1'b0 || x !== 2'd0 || y !== 1'b0) begin
      fails++; $display("FAIL reset_pos got m=%b x=%0d y=%0d want 0 0 0", mask, x, y);
    end
    tests++;
    if (match_count !== 4'd0) begin
      fails++; $display("FAIL reset_count got %0d want 0", match_count);
    end
    rst_n = 1'b1;
    bx = 0; by = 0; bacc = 0; bmc = 0;
    $display("[TB] reset done");
  endtask

  task automatic test_latency;
    out_t e, a;
    bit ok;
    set_bounds(F0, F60, F05, F1, F05, F1);
    send_px(F30, F08, F09, 1'b1);
    @(negedge clk); in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL latency_e0 got ov=%b want 0", out_valid); end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL latency_e1 got ov=%b want 0", out_valid); end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b1 || mask !== 1'b1) begin
      fails++; $display("FAIL latency_e2 got ov=%b m=%b want 1 1", out_valid, mask);
    end
    pad(F30, F08, F09, 1'b1);
    drain(ok);
    tests++;
    if (!ok || act_q.size() != exp_q.size()) begin
      fails++; $display("FAIL latency_count got %0d outputs want %0d", act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); tests++;
      if (a !== e) begin
        fails++; $display("FAIL latency_px got m=%b x=%0d y=%0d fd=%b mc=%0d want m=%b x=%0d y=%0d fd=%b mc=%0d",
                          a.m, a.x, a.y, a.fd, a.mc, e.m, e.x, e.y, e.fd, e.mc);
      end else $display("[TB] latency px (%0d,%0d) m=%b mc=%0d", a.x, a.y, a.m, a.mc);
    end
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_wrap;
    out_t e, a;
    bit ok;
    set_bounds(F340, F20, F05, F1, F05, F1);
    send_px(F350, F08, F09, 1'b1);
    send_px(F10,  F08, F09, 1'b1);
    send_px(F180, F08, F09, 1'b0);
    send_px(F340, F08, F09, 1'b1);
    send_px(F20,  F08, F09, 1'b1);
    pad(F180, F08, F09, 1'b0);
    drain(ok);
    tests++;
    if (!ok || act_q.size() != exp_q.size()) begin
      fails++; $display("FAIL wrap_count got %0d outputs want %0d", act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); tests++;
      if (a !== e) begin
        fails++; $display("FAIL wrap_px got m=%b x=%0d y=%0d fd=%b mc=%0d want m=%b x=%0d y=%0d fd=%b mc=%0d",
                          a.m, a.x, a.y, a.fd, a.mc, e.m, e.x, e.y, e.fd, e.mc);
      end else $display("[TB] wrap px (%0d,%0d) m=%b mc=%0d", a.x, a.y, a.m, a.mc);
    end
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_nan_zero;
    out_t e, a;
    bit ok;
    set_bounds(F0, F60, F0, F1, F05, F1);
    send_px(F30, FNAN,  F09,  1'b0);
    send_px(F30, FNEG0, F09,  1'b1);
    send_px(F30, F0,    F09,  1'b1);
    send_px(F30, F08,   FNAN, 1'b0);
    send_px(F30, FN05,  F09,  1'b0);
    send_px(FNAN, F08,  F09,  1'b0);
    pad(F30, F08, F09, 1'b1);
    drain(ok);
    tests++;
    if (!ok || act_q.size() != exp_q.size()) begin
      fails++; $display("FAIL nan_count got %0d outputs want %0d", act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); tests++;
      if (a !== e) begin
        fails++; $display("FAIL nan_px got m=%b x=%0d y=%0d fd=%b mc=%0d want m=%b x=%0d y=%0d fd=%b mc=%0d",
                          a.m, a.x, a.y, a.fd, a.mc, e.m, e.x, e.y, e.fd, e.mc);
      end else $display("[TB] nan px (%0d,%0d) m=%b mc=%0d", a.x, a.y, a.m, a.mc);
    end
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_frame_gaps;
    out_t e, a;
    bit ok, m;
    set_bounds(F0, F60, F05, F1, F05, F1);
    stray_fd = 0;
    for (int i = 0; i < 8; i++) begin
      m = (i == 1) || (i == 4) || (i == 6);
      send_px(m ? F30 : F180, F08, F09, m);
      if (i % 3 == 0) idle(i % 4 + 1);
    end
    drain(ok);
    tests++;
    if (!ok || act_q.size() != exp_q.size()) begin
      fails++; $display("FAIL frame_count got %0d outputs want %0d", act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); tests++;
      if (a !== e) begin
        fails++; $display("FAIL frame_px got m=%b x=%0d y=%0d fd=%b mc=%0d want m=%b x=%0d y=%0d fd=%b mc=%0d",
                          a.m, a.x, a.y, a.fd, a.mc, e.m, e.x, e.y, e.fd, e.mc);
      end else $display("[TB] frame px (%0d,%0d) m=%b fd=%b mc=%0d", a.x, a.y, a.m, a.fd, a.mc);
    end
    exp_q.delete(); act_q.delete();
    idle(4);
    tests++;
    if (match_count !== bmc[3:0] || stray_fd != 0) begin
      fails++; $display("FAIL frame_hold got mc=%0d stray_fd=%0d want mc=%0d stray_fd=0",
                        match_count, stray_fd, bmc);
    end
  endtask

  task automatic test_shadow;
    out_t e, a;
    bit ok;
    set_bounds(F0, F60, F05, F1, F05, F1);
    send_px(F30, F08, F09, 1'b1);
    send_px(F30, F08, F09, 1'b1);
    h_hi = F20;
    pad(F30, F08, F09, 1'b1);
    send_px(F30, F08, F09, 1'b0);
    send_px(F10, F08, F09, 1'b1);
    pad(F30, F08, F09, 1'b0);
    drain(ok);
    tests++;
    if (!ok || act_q.size() != exp_q.size()) begin
      fails++; $display("FAIL shadow_count got %0d outputs want %0d", act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); tests++;
      if (a !== e) begin
        fails++; $display("FAIL shadow_px got m=%b x=%0d y=%0d fd=%b mc=%0d want m=%b x=%0d y=%0d fd=%b mc=%0d",
                          a.m, a.x, a.y, a.fd, a.mc, e.m, e.x, e.y, e.fd, e.mc);
      end else $display("[TB] shadow px (%0d,%0d) m=%b mc=%0d", a.x, a.y, a.m, a.mc);
    end
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_mid_reset;
    out_t e, a;
    bit ok, m;
    set_bounds(F0, F60, F05, F1, F05, F1);
    send_px(F30, F08, F09, 1'b1);
    send_px(F30, F08, F09, 1'b1);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b1; h = F30; s = F08; v = F09;
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if ({out_valid, mask, x, y, frame_done, match_count} !== 10'd0) begin
      fails++; $display("FAIL midreset_out got ov=%b m=%b x=%0d y=%0d fd=%b mc=%0d want all 0",
                        out_valid, mask, x, y, frame_done, match_count);
    end
    tests++;
    if (act_q.size() != 0) begin
      fails++; $display("FAIL midreset_abort got %0d outputs want 0", act_q.size());
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete(); act_q.delete();
    bx = 0; by = 0; bacc = 0; bmc = 0;
    for (int i = 0; i < 8; i++) begin
      m = (i < 3);
      send_px(m ? F30 : F180, F08, F09, m);
    end
    drain(ok);
    tests++;
    if (!ok || act_q.size() != exp_q.size()) begin
      fails++; $display("FAIL restart_count got %0d outputs want %0d", act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); tests++;
      if (a !== e) begin
        fails++; $display("FAIL restart_px got m=%b x=%0d y=%0d fd=%b mc=%0d want m=%b x=%0d y=%0d fd=%b mc=%0d",
                          a.m, a.x, a.y, a.fd, a.mc, e.m, e.x, e.y, e.fd, e.mc);
      end else $display("[TB] restart px (%0d,%0d) m=%b mc=%0d", a.x, a.y, a.m, a.mc);
    end
    exp_q.delete(); act_q.delete();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_wrap();
    test_nan_zero();
    test_frame_gaps();
    test_shadow();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #(2 * K * 20000);
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
